multicycle_controller: RTL
==========================

// Module: multicycle_controller
// PURPOSE
// - Main control FSM for the multicycle RV32I subset core: lw, sw, R-type (add/sub/and/or/slt/xor),
//   I-type ALU (addi/andi/ori/slti/xori), beq, jal.
// - Sequences the shared ALU, memory and register file over 3-5 cycles per instruction.
// - Sits between the instruction register (opcode/funct fields) and the datapath mux selects and write strobes.
// - Produces ALUControl through the existing ALU decoder.
// PARAMETERS
// - TRAP_ILLEGAL  1  1: an unknown opcode in DECODE pulses illegal and returns to FETCH; 0: no pulse, same return.
// PORTS
// - clk        in   1  core clock; all state changes on rising edge
// - reset      in   1  asynchronous, active-high; forces FSM to FETCH
// - opcode     in   7  instr[6:0] from the instruction register
// - funct3     in   3  instr[14:12]
// - funct7b5   in   1  instr[30]
// - zero       in   1  ALU zero flag (beq compare)
// - PCWrite    out  1  PC register enable = PCUpdate | (Branch & zero)
// - AdrSrc     out  1  memory address mux: 0 PC, 1 ALUOut
// - MemWrite   out  1  data memory write strobe
// - IRWrite    out  1  instruction register / OldPC enable
// - ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult
// - ALUSrcA    out  2  00 PC, 01 OldPC, 10 rs1 (A)
// - ALUSrcB    out  2  00 rs2 (WriteData), 01 ImmExt, 10 constant 4
// - RegWrite   out  1  register file write strobe
// - ImmSrc     out  2  00 I, 01 S, 10 B, 11 J (combinational from opcode)
// - ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 xor
// - illegal    out  1  one-cycle pulse in DECODE on an unsupported opcode
// - state_dbg  out  4  current state encoding, for debug and bench checks
// BEHAVIOUR
// - Moore outputs decode from the state register. Any output not listed for a state is 0.
// - ALUOp: 00 add, 01 sub, 10 funct-decode.
// - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
//   -> DECODE.
// - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target into ALUOut).
//   - 0000011/0100011 -> MEMADR
//   - 0110011 -> EXECUTER
//   - 0010011 -> EXECUTEI
//   - 1101111 -> JAL
//   - 1100011 -> BEQ
//   - other -> FETCH with illegal=1 (if TRAP_ILLEGAL)
// - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. opcode[5]=0 -> MEMREAD, 1 -> MEMWRITE.
// - MEMREAD: AdrSrc=1, ResultSrc=00 -> MEMWB.
// - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
// - MEMWRITE: AdrSrc=1, MemWrite=1 -> FETCH.
// - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
// - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
// - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
// - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB (rd = OldPC+4).
// - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
//   PCWrite=zero in this cycle.
// - Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3. No stalls, no handshake.
//   Memory is single-cycle.
// - ALU decode (ALUOp=10):
//   - sub only when funct3=000 and {opcode[5],funct7b5}=11, so addi with imm[10]=1 stays add.
//   - Unsupported funct3 gives ALUControl=000, never X.
// - ImmSrc: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
// - Reset:
//   - Asynchronous assert drives state=FETCH immediately.
//   - While reset=1, all strobes (PCWrite, IRWrite, MemWrite, RegWrite, illegal) = 0. Selects show FETCH values.
//   - Reset asserted mid-instruction abandons it with no partial write.
//   - First FETCH strobes occur on the first rising edge after deassert.
// - Illegal/unused state encodings recover to FETCH on the next edge.
// STRUCTURE
// - Package riscv_pkg holds:
//   - opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL)
//   - ALUOp enum
//   - ALUControl codes
//   - typedef enum logic [3:0] state_t (FETCH=0 .. BEQ=10)
// - Sub-module: aludec (existing ALU decoder) instantiated unchanged, fed opcode/funct3/funct7b5/ALUOp.
// - The FSM and the ImmSrc decode live in this module.
// TESTING
// - lw (0000011): reset, release -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB.
//   IRWrite only in cycle 1, RegWrite only in cycle 5, ResultSrc=01 in cycle 5.
// - sw (0100011): MemWrite=1 and AdrSrc=1 exactly in cycle 4, RegWrite never 1, back in FETCH at cycle 5.
// - R-type sub (funct3=000, funct7b5=1): ALUControl=001 in EXECUTER.
//   addi with funct7b5=1 -> ALUControl=000. slt -> 101, xor -> 110.
// - beq: zero=1 -> PCWrite=1 in BEQ state.
//   zero=0 -> PCWrite=0. Next state FETCH after 3 cycles either way.
// - jal (1101111): PCWrite=1 in JAL, then RegWrite=1 with ResultSrc=00 in ALUWB, ImmSrc=11 throughout.
// - Opcode 0000000: illegal pulses one cycle in DECODE, FETCH follows.
//   Reset asserted during MEMREAD -> state_dbg=0 same cycle, all strobes 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, ALU
// operation classes, ALU control codes, FSM state encoding and the
// immediate-format decode.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  // Immediate format select; unknown opcodes fall back to the I format.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_I: imm_src_of = 2'b00;
      OP_STORE:      imm_src_of = 2'b01;
      OP_BEQ:        imm_src_of = 2'b10;
      OP_JAL:        imm_src_of = 2'b11;
      default:       imm_src_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps the FSM's ALU operation class plus the instruction
// funct fields onto the ALU's control code.
module aludec
  import riscv_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_t     alu_op,
  output logic [2:0] alu_control
);

  // Combinational decode; every unsupported pattern resolves to add.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type with funct7[5] set subtracts; addi keeps add even
          // when imm[10] happens to be 1.
          3'b000:  alu_control = (opb5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. Sequences the shared ALU,
// memory and register file; outputs are Moore-decoded from the state
// register, with all write strobes held low while reset is asserted.
module multicycle_controller
  import riscv_pkg::*;
#(
  parameter bit TRAP_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state_q;
  state_t state_d;
  aluop_t alu_op;
  logic   pc_update;
  logic   branch;
  logic   ir_write_raw;
  logic   mem_write_raw;
  logic   reg_write_raw;
  logic   known_op;

  assign known_op = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                    (opcode == OP_R)    || (opcode == OP_I)     ||
                    (opcode == OP_JAL)  || (opcode == OP_BEQ);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection; unused encodings recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECUTER;
          OP_I:              state_d = EXECUTEI;
          OP_JAL:            state_d = JAL;
          OP_BEQ:            state_d = BEQ;
          default:           state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = FETCH;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Moore output decode; anything not set for a state stays 0.
  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        ir_write_raw = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB: reg_write_raw = 1'b1;
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite   = ~reset & (pc_update | (branch & zero));
  assign IRWrite   = ~reset & ir_write_raw;
  assign MemWrite  = ~reset & mem_write_raw;
  assign RegWrite  = ~reset & reg_write_raw;
  assign illegal   = TRAP_ILLEGAL & ~reset & (state_q == DECODE) & ~known_op;
  assign ImmSrc    = imm_src_of(opcode);
  assign state_dbg = state_q;

  aludec u_aludec (
    .opb5        (opcode[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_op      (alu_op),
    .alu_control (ALUControl)
  );

endmodule
